// File: rtl/spart_bus_if.sv
// Processor-side I/O bus of the SPART: chip select, direction, address and
// the split data bus with its drive enable.
interface spart_bus_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe;

    modport master (output iocs, iorw, ioaddr, db_in, input db_out, db_oe);
    modport slave  (input iocs, iorw, ioaddr, db_in, output db_out, db_oe);
endinterface

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: I/O decode, programmable baud divisor, tx baud ticks
// and start-bit aligned rx baud ticks for one 10-bit frame at a time.
module spart_bus_ctrl #(
    parameter logic [15:0] DIV_RESET = 16'd434,
    parameter int          RX_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    spart_bus_if.slave  bus,
    input  logic        rxd,
    input  logic        rda,
    input  logic [7:0]  rx_data,
    input  logic        tbr,
    output logic        receive_read_en,
    output logic        receive_baud,
    output logic        tx_write_en,
    output logic [7:0]  tx_data,
    output logic        transmit_baud
);

    typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;

    localparam logic [15:0] DIV_RESET_EFF = (DIV_RESET < 16'd2) ? 16'd2 : DIV_RESET;
    localparam logic [3:0]  LAST_BIT      = 4'(RX_BITS - 1);

    logic        rd_access, wr_access, div_wr;
    logic [15:0] div, div_next, eff_div, eff_div_next;
    logic        tx_ovf;
    logic [15:0] tx_cnt;
    logic        rxd_meta, rxd_sync;
    rx_state_t   rx_state, rx_state_next;
    logic [15:0] rx_cnt, rx_cnt_next;
    logic [3:0]  bit_cnt, bit_cnt_next;

    assign rd_access = bus.iocs & bus.iorw;
    assign wr_access = bus.iocs & ~bus.iorw;
    assign div_wr    = wr_access & bus.ioaddr[1];

    always_comb begin
        bus.db_oe  = rd_access;
        bus.db_out = 8'h00;
        if (rd_access) begin
            case (bus.ioaddr)
                2'b00:   bus.db_out = rx_data;
                2'b01:   bus.db_out = {5'b0, tx_ovf, rda, tbr};
                2'b10:   bus.db_out = div[7:0];
                default: bus.db_out = div[15:8];
            endcase
        end
    end

    // Counters reload from the divisor being written so the new rate takes
    // effect on the very next cycle.
    always_comb begin
        div_next = div;
        if (wr_access && bus.ioaddr == 2'b10) div_next[7:0]  = bus.db_in;
        if (wr_access && bus.ioaddr == 2'b11) div_next[15:8] = bus.db_in;
    end

    assign eff_div      = (div < 16'd2) ? 16'd2 : div;
    assign eff_div_next = (div_next < 16'd2) ? 16'd2 : div_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div             <= DIV_RESET;
            tx_ovf          <= 1'b0;
            receive_read_en <= 1'b0;
            tx_write_en     <= 1'b0;
            tx_data         <= 8'h00;
        end else begin
            div             <= div_next;
            receive_read_en <= rd_access && bus.ioaddr == 2'b00 && rda;
            tx_write_en     <= wr_access && bus.ioaddr == 2'b00 && tbr;
            if (wr_access && bus.ioaddr == 2'b00 && tbr) tx_data <= bus.db_in;
            // A dropped write in the same cycle as a status read keeps the flag set.
            if (wr_access && bus.ioaddr == 2'b00 && !tbr) tx_ovf <= 1'b1;
            else if (rd_access && bus.ioaddr == 2'b01)    tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tx_cnt <= DIV_RESET_EFF;
        else if (div_wr)          tx_cnt <= eff_div_next;
        else if (tx_write_en)     tx_cnt <= eff_div;
        else if (tx_cnt <= 16'd1) tx_cnt <= eff_div;
        else                      tx_cnt <= tx_cnt - 16'd1;
    end

    assign transmit_baud = (tx_cnt == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= DIV_RESET_EFF;
            bit_cnt  <= 4'd0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            bit_cnt  <= bit_cnt_next;
        end
    end

    // Half-period preload puts the first tick in the middle of the start bit.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        bit_cnt_next  = bit_cnt;
        receive_baud  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_sync) begin
                    rx_state_next = RX_FRAME;
                    rx_cnt_next   = {1'b0, eff_div[15:1]};
                    bit_cnt_next  = 4'd0;
                end
            end
            RX_FRAME: begin
                if (rx_cnt <= 16'd1) begin
                    receive_baud = 1'b1;
                    rx_cnt_next  = eff_div;
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) rx_state_next = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt - 16'd1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
        if (div_wr) begin
            rx_state_next = RX_IDLE;
            rx_cnt_next   = eff_div_next;
            bit_cnt_next  = 4'd0;
        end
    end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: a table of single bus accesses plus
// hand-written sequences for baud timing, overflow and rx framing.
module tb_spart_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       rda;
    logic [7:0] rx_data;
    logic       tbr;
    logic       receive_read_en;
    logic       receive_baud;
    logic       tx_write_en;
    logic [7:0] tx_data;
    logic       transmit_baud;

    int vec_count = 0;
    int miscompares = 0;

    spart_bus_if bus ();

    spart_bus_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .rxd             (rxd),
        .rda             (rda),
        .rx_data         (rx_data),
        .tbr             (tbr),
        .receive_read_en (receive_read_en),
        .receive_baud    (receive_baud),
        .tx_write_en     (tx_write_en),
        .tx_data         (tx_data),
        .transmit_baud   (transmit_baud)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       iocs;
        logic       iorw;
        logic [1:0] ioaddr;
        logic [7:0] db_in;
        logic       rda;
        logic [7:0] rx_data;
        logic       tbr;
        logic       exp_oe;
        logic [7:0] exp_out;
        logic       exp_rre;
        logic       exp_twe;
        logic [7:0] exp_txd;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.iocs   = v.iocs;
        bus.iorw   = v.iorw;
        bus.ioaddr = v.ioaddr;
        bus.db_in  = v.db_in;
        rda        = v.rda;
        rx_data    = v.rx_data;
        tbr        = v.tbr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
        step();
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = addr;
        bus.db_in  = data;
        step();
        bus.iocs = 1'b0;
    endtask

    task automatic countToTxTick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!transmit_baud && n <= limit);
    endtask

    task automatic watchRx(input int cycles, output int first, output int last, output int count);
        first = -1;
        last  = -1;
        count = 0;
        for (int i = 1; i <= cycles; i++) begin
            step();
            if (i == 16) rxd = 1'b1;
            if (receive_baud) begin
                if (first < 0) first = i;
                last = i;
                count++;
            end
        end
    endtask

    initial begin
        int n, first, last, count;

        vecs[0] = '{1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 8'hA5, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[7] = '{1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[8] = '{1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5};

        rst_n      = 1'b0;
        rxd        = 1'b1;
        rda        = 1'b0;
        rx_data    = 8'h00;
        tbr        = 1'b0;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        bus.db_in  = 8'h00;

        // Reset state, then tx tick cadence at the reset divisor
        repeat (3) step();
        checkOutput("reset db_oe", 16'(bus.db_oe), 16'h0);
        checkOutput("reset db_out", 16'(bus.db_out), 16'h0);
        checkOutput("reset tx_data", 16'(tx_data), 16'h0);
        checkOutput("reset pulses", 16'({receive_read_en, tx_write_en, receive_baud, transmit_baud}), 16'h0);
        rst_n = 1'b1;
        countToTxTick(1000, n);
        checkOutput("first tx tick after reset", 16'(n), 16'd433);
        countToTxTick(1000, n);
        checkOutput("tx period 434", 16'(n), 16'd434);
        watchRx(300, first, last, count);
        checkOutput("no rx ticks while idle", 16'(count), 16'd0);

        // Single-access vector table
        for (int i = 0; i < 9; i++) begin
            step();
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d db_oe", i), 16'(bus.db_oe), 16'(vecs[i].exp_oe));
            checkOutput($sformatf("vec%0d db_out", i), 16'(bus.db_out), 16'(vecs[i].exp_out));
            step();
            bus.iocs = 1'b0;
            checkOutput($sformatf("vec%0d receive_read_en", i), 16'(receive_read_en), 16'(vecs[i].exp_rre));
            checkOutput($sformatf("vec%0d tx_write_en", i), 16'(tx_write_en), 16'(vecs[i].exp_twe));
            checkOutput($sformatf("vec%0d tx_data", i), 16'(tx_data), 16'(vecs[i].exp_txd));
        end

        // Dropped write sets sticky overflow; status read clears it
        rda = 1'b0;
        tbr = 1'b0;
        busWrite(2'b00, 8'hC3);
        checkOutput("dropped write no pulse", 16'(tx_write_en), 16'h0);
        checkOutput("dropped write tx_data kept", 16'(tx_data), 16'hA5);
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b01;
        #1;
        checkOutput("status shows overflow", 16'(bus.db_out), 16'h04);
        step();
        #1;
        checkOutput("status overflow cleared", 16'(bus.db_out), 16'h00);
        bus.iocs = 1'b0;
        tbr = 1'b1;
        busWrite(2'b00, 8'hC3);
        checkOutput("accepted write pulse", 16'(tx_write_en), 16'h1);
        checkOutput("accepted write tx_data", 16'(tx_data), 16'hC3);
        step();
        checkOutput("write pulse one cycle", 16'(tx_write_en), 16'h0);

        // Divisor 16: tx period and reload on tx_write_en
        busWrite(2'b10, 8'd16);
        busWrite(2'b11, 8'd0);
        countToTxTick(1000, n);
        checkOutput("first tx tick after DB write", 16'(n), 16'd15);
        countToTxTick(1000, n);
        checkOutput("tx period 16", 16'(n), 16'd16);
        repeat (5) step();
        busWrite(2'b00, 8'h77);
        checkOutput("tx_data 77", 16'(tx_data), 16'h77);
        step();
        countToTxTick(1000, n);
        checkOutput("tx tick after load", 16'(n), 16'd15);

        // Full rx frame at divisor 16
        step();
        rxd = 1'b0;
        watchRx(200, first, last, count);
        checkOutput("rx first tick", 16'(first), 16'd10);
        checkOutput("rx last tick", 16'(last), 16'd154);
        checkOutput("rx tick count", 16'(count), 16'd10);

        // Divisor write mid-frame abandons the frame; next start uses new rate
        step();
        rxd = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (receive_baud) n = i;
        end
        checkOutput("abort frame first tick", 16'(n), 16'd10);
        rxd = 1'b1;
        step();
        busWrite(2'b10, 8'd8);
        watchRx(60, first, last, count);
        checkOutput("no ticks after abort", 16'(count), 16'd0);
        step();
        rxd = 1'b0;
        watchRx(30, first, last, count);
        checkOutput("new rate first tick", 16'(first), 16'd6);
        checkOutput("new rate tick count in window", 16'(count), 16'd4);

        // Divisor 0 clamps to period 2
        busWrite(2'b10, 8'd0);
        countToTxTick(100, n);
        countToTxTick(100, n);
        checkOutput("tx period clamp 2", 16'(n), 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
